// File: rtl/sieve_ctrl_if.sv
// Handshake/RAM bundle between the top-level control, the prime RAM and sieve_ctrl.
// prime_count exists only when SIEVE_CNT_EN is defined.
interface sieve_ctrl_if #(
    parameter int AW = 20
);
    logic          start;
    logic          busy;
    logic          done;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic          ram_wdata;
    logic [AW-1:0] ram_raddr;
    logic          ram_rdata;
    logic          q_valid;
    logic [AW-1:0] q_num;
    logic          q_ready;
    logic          r_valid;
    logic          r_prime;
`ifdef SIEVE_CNT_EN
    logic [AW-1:0] prime_count;
`endif

    // master: control logic plus RAM read data; slave: the sequencer
    modport master (
`ifdef SIEVE_CNT_EN
        input  prime_count,
`endif
        output start, ram_rdata, q_valid, q_num,
        input  busy, done, ram_we, ram_waddr, ram_wdata, ram_raddr,
        input  q_ready, r_valid, r_prime
    );

    modport slave (
`ifdef SIEVE_CNT_EN
        output prime_count,
`endif
        input  start, ram_rdata, q_valid, q_num,
        output busy, done, ram_we, ram_waddr, ram_wdata, ram_raddr,
        output q_ready, r_valid, r_prime
    );
endinterface

// File: rtl/sieve_ctrl.sv
// Sieve of Eratosthenes sequencer for a 1-bit dual-port prime RAM, then primality query server.
// Optional prime counting pass enabled by defining SIEVE_CNT_EN.
module sieve_ctrl #(
    parameter int N  = 1023,
    parameter int AW = 20
) (
    input  logic         clk,
    input  logic         rst,
    sieve_ctrl_if.slave  bus
);
    typedef enum logic [3:0] {
        IDLE, CLEAR, RD_I, WAIT, CHK, MARK, NEXT, DONE
`ifdef SIEVE_CNT_EN
        , COUNT
`endif
    } state_t;

    localparam logic [AW-1:0]   NA  = AW'(N);
    localparam logic [AW:0]     NJ  = (AW+1)'(N);
    localparam logic [2*AW-1:0] NSQ = (2*AW)'(N);

    state_t          r_state;
    logic [AW-1:0]   r_i;
    logic [2*AW-1:0] r_sq;
    logic [AW:0]     r_j;
    logic            r_busy, r_done, r_we, r_wdata;
    logic [AW-1:0]   r_waddr, r_raddr;
    logic [1:0]      r_q_vld_pipe, r_q_ovr_pipe;
    logic            r_rvalid, r_rprime;
`ifdef SIEVE_CNT_EN
    logic [AW:0]     r_caddr;
    logic [1:0]      r_vld_pipe;
    logic [AW-1:0]   r_pcnt;
`endif

    logic            w_q_acc, w_q_ovr;
    logic [AW:0]     w_j_nxt;
    logic [2*AW-1:0] w_sq_nxt;

    assign w_q_acc  = bus.q_valid & r_done;
    assign w_q_ovr  = (bus.q_num < AW'(2)) || (bus.q_num > NA);
    assign w_j_nxt  = r_j + {1'b0, r_i};
    // (i+1)^2 = i^2 + 2i + 1
    assign w_sq_nxt = r_sq + {{(AW-1){1'b0}}, r_i, 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_i          <= AW'(2);
            r_sq         <= (2*AW)'(4);
            r_j          <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_we         <= 1'b0;
            r_wdata      <= 1'b0;
            r_waddr      <= '0;
            r_raddr      <= '0;
            r_q_vld_pipe <= '0;
            r_q_ovr_pipe <= '0;
            r_rvalid     <= 1'b0;
            r_rprime     <= 1'b0;
`ifdef SIEVE_CNT_EN
            r_caddr      <= '0;
            r_vld_pipe   <= '0;
            r_pcnt       <= '0;
`endif
        end else begin
            // query pipeline is independent of the FSM so in-flight results survive a restart
            r_q_vld_pipe <= {r_q_vld_pipe[0], w_q_acc};
            r_q_ovr_pipe <= {r_q_ovr_pipe[0], w_q_ovr};
            r_rvalid     <= r_q_vld_pipe[1];
            r_rprime     <= r_q_vld_pipe[1] & ~r_q_ovr_pipe[1] & ~bus.ram_rdata;
            if (w_q_acc)
                r_raddr <= bus.q_num;
`ifdef SIEVE_CNT_EN
            r_vld_pipe <= {r_vld_pipe[0], (r_state == COUNT) && (r_caddr <= NJ)};
`endif

            case (r_state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        r_state <= CLEAR;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_we    <= 1'b1;
                        r_wdata <= 1'b0;
                        r_waddr <= '0;
`ifdef SIEVE_CNT_EN
                        r_pcnt  <= '0;
                        r_caddr <= (AW+1)'(2);
`endif
                    end
                end
                CLEAR: begin
                    if (r_waddr == NA) begin
                        r_we <= 1'b0;
                        r_i  <= AW'(2);
                        r_sq <= (2*AW)'(4);
                        if (N < 4) begin
`ifdef SIEVE_CNT_EN
                            r_state <= COUNT;
`else
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
`endif
                        end else begin
                            r_state <= RD_I;
                        end
                    end else begin
                        r_waddr <= r_waddr + AW'(1);
                    end
                end
                RD_I: begin
                    r_raddr <= r_i;
                    r_state <= WAIT;
                end
                WAIT: r_state <= CHK;
                CHK: begin
                    if (!bus.ram_rdata) begin
                        r_j     <= {1'b0, r_sq[AW-1:0]};
                        r_we    <= 1'b1;
                        r_wdata <= 1'b1;
                        r_waddr <= r_sq[AW-1:0];
                        r_state <= MARK;
                    end else begin
                        r_state <= NEXT;
                    end
                end
                MARK: begin
                    if (w_j_nxt > NJ) begin
                        r_we    <= 1'b0;
                        r_state <= NEXT;
                    end else begin
                        r_j     <= w_j_nxt;
                        r_waddr <= w_j_nxt[AW-1:0];
                    end
                end
                NEXT: begin
                    r_i  <= r_i + AW'(1);
                    r_sq <= w_sq_nxt;
                    if (w_sq_nxt > NSQ) begin
`ifdef SIEVE_CNT_EN
                        r_state <= COUNT;
`else
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
`endif
                    end else begin
                        r_state <= RD_I;
                    end
                end
`ifdef SIEVE_CNT_EN
                COUNT: begin
                    if (r_caddr <= NJ) begin
                        r_raddr <= r_caddr[AW-1:0];
                        r_caddr <= r_caddr + (AW+1)'(1);
                    end
                    if (r_vld_pipe[1] && !bus.ram_rdata)
                        r_pcnt <= r_pcnt + AW'(1);
                    // finish once all reads are issued and the pipeline has drained
                    if ((r_caddr > NJ) && (r_vld_pipe == 2'b00)) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.q_ready   = r_done;
    assign bus.ram_we    = r_we;
    assign bus.ram_waddr = r_waddr;
    assign bus.ram_wdata = r_wdata;
    assign bus.ram_raddr = r_raddr;
    assign bus.r_valid   = r_rvalid;
    assign bus.r_prime   = r_rprime;
`ifdef SIEVE_CNT_EN
    assign bus.prime_count = r_pcnt;
`endif
endmodule

// File: tb/tb_sieve_ctrl.sv
// Self-checking bench for sieve_ctrl (N=30) with a behavioural RAM and trial-division reference.
module tb_sieve_ctrl;
    localparam int N  = 30;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sieve_ctrl_if #(.AW(AW)) bus();
    sieve_ctrl #(.N(N), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic scramble = 1'b1;
    logic mem [0:255];

    // dual-port RAM, synchronous read-old behaviour
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (scramble) begin
            for (int k = 0; k < 256; k++) mem[k] <= 1'($urandom);
        end else if (bus.ram_we) begin
            mem[bus.ram_waddr] <= bus.ram_wdata;
        end
        bus.ram_rdata <= mem[bus.ram_raddr];
    end

    int   res_cyc[$];
    logic res_val[$];
    int   clr_addr[$];
    int   mark_addr[$];
    int   clr_runs = 0;

    always @(negedge clk) begin
        if (bus.r_valid) begin
            res_cyc.push_back(cyc);
            res_val.push_back(bus.r_prime);
        end
        if (bus.ram_we && !bus.ram_wdata) begin
            clr_addr.push_back(int'(bus.ram_waddr));
            if (bus.ram_waddr == '0) clr_runs++;
        end
        if (bus.ram_we && bus.ram_wdata) mark_addr.push_back(int'(bus.ram_waddr));
    end

    logic [22:0] outs;
    assign outs = {bus.busy, bus.done, bus.ram_we, bus.ram_wdata, bus.q_ready,
                   bus.r_valid, bus.r_prime, bus.ram_waddr, bus.ram_raddr};

    function automatic bit is_prime(int n);
        if (n < 2 || n > N) return 1'b0;
        for (int d = 2; d * d <= n; d++) if (n % d == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int model_count();
        int c = 0;
        for (int n = 0; n <= N; n++) if (is_prime(n)) c++;
        return c;
    endfunction

    task automatic pulse_start();
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!bus.done && k < 3000) begin @(negedge clk); k++; end
        if (!bus.done) begin
            checks++; failures++;
            $display("FAIL %s: done never rose within %0d cycles", tag, k);
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.q_valid = 1'b0; bus.q_num = '0;
        rst = 1'b1; scramble = 1'b1;
        repeat (3) @(negedge clk);
        scramble = 1'b0;
        checks++;
        if (outs !== '0) begin failures++; $display("FAIL reset_outputs: got %h want 0", outs); end
`ifdef SIEVE_CNT_EN
        checks++;
        if (bus.prime_count !== '0) begin failures++; $display("FAIL reset_count: got %0d want 0", bus.prime_count); end
`endif
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL idle_after_reset: busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_sieve();
        int b0 = clr_addr.size();
        int m0 = mark_addr.size();
        int bad = 0;
        bit marked [0:N];
        pulse_start();
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            failures++; $display("FAIL busy_after_start: busy=%b done=%b want 1 0", bus.busy, bus.done);
        end
        wait_done("sieve");
        checks++;
        if (bus.busy !== 1'b0 || bus.q_ready !== 1'b1) begin
            failures++; $display("FAIL done_state: busy=%b q_ready=%b want 0 1", bus.busy, bus.q_ready);
        end
        checks++;
        if (clr_addr.size() - b0 != N + 1) begin
            failures++; $display("FAIL clear_len: got %0d writes want %0d", clr_addr.size() - b0, N + 1);
        end
        for (int k = 0; k <= N && b0 + k < clr_addr.size(); k++) if (clr_addr[b0 + k] != k) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL clear_addrs: %0d out of order want 0", bad); end
        for (int n = 0; n <= N; n++) marked[n] = 1'b0;
        bad = 0;
        for (int k = m0; k < mark_addr.size(); k++) begin
            if (mark_addr[k] > N || is_prime(mark_addr[k]) || mark_addr[k] < 4) bad++;
            else marked[mark_addr[k]] = 1'b1;
        end
        for (int n = 4; n <= N; n++) if (!is_prime(n) && !marked[n]) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL mark_set: %0d wrong or missing marks want 0", bad); end
    endtask

    task automatic test_queries();
        int nums[$] = '{2, 3, 29, 27, 25, 1, 0, 31};
        int   ec[$];
        logic ev[$];
        int base = res_cyc.size();
        for (int k = 0; k < 24; k++) nums.push_back(int'($urandom_range(0, 40)));
        foreach (nums[k]) begin
            @(negedge clk);
            bus.q_valid = 1'b1; bus.q_num = AW'(nums[k]);
            if (bus.q_ready) begin ec.push_back(cyc + 3); ev.push_back(is_prime(nums[k])); end
            if (k >= 8 && $urandom_range(0, 3) == 0) begin @(negedge clk); bus.q_valid = 1'b0; end
        end
        @(negedge clk); bus.q_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (res_cyc.size() - base != ec.size()) begin
            failures++; $display("FAIL query_count: got %0d results want %0d", res_cyc.size() - base, ec.size());
        end
        for (int k = 0; k < ec.size() && base + k < res_cyc.size(); k++) begin
            checks++;
            if (res_val[base + k] !== ev[k] || res_cyc[base + k] != ec[k]) begin
                failures++;
                $display("FAIL query_%0d: got prime=%b at cyc %0d want prime=%b at cyc %0d",
                         k, res_val[base + k], res_cyc[base + k], ev[k], ec[k]);
            end
        end
    endtask

    task automatic test_busy_query();
        int base;
        int bad = 0;
        pulse_start();
        base = res_cyc.size();
        for (int k = 0; k < 10; k++) begin
            bus.q_valid = 1'b1; bus.q_num = AW'($urandom_range(0, 30));
            @(negedge clk);
            if (bus.q_ready !== 1'b0) bad++;
        end
        bus.q_valid = 1'b0;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL busy_qready: high %0d times want 0", bad); end
        wait_done("busy_query");
        repeat (3) @(negedge clk);
        checks++;
        if (res_cyc.size() != base) begin
            failures++; $display("FAIL busy_no_result: got %0d results want 0", res_cyc.size() - base);
        end
    endtask

    task automatic test_reset_mid_mark();
        int k = 0;
        int base;
        int bad = 0;
        int primes = 0;
        pulse_start();
        while (!(bus.ram_we && bus.ram_wdata && bus.ram_waddr == AW'(9)) && k < 2000) begin
            @(negedge clk); k++;
        end
        checks++;
        if (k >= 2000) begin failures++; $display("FAIL mark_i3_seen: not reached want write to 9"); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (outs !== '0) begin failures++; $display("FAIL async_reset: got %h want 0", outs); end
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) begin failures++; $display("FAIL done_after_abort: got %b want 0", bus.done); end
        pulse_start();
        wait_done("after_abort");
        base = res_cyc.size();
        for (int n = 0; n <= N; n++) begin
            bus.q_valid = 1'b1; bus.q_num = AW'(n);
            @(negedge clk);
        end
        bus.q_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (res_cyc.size() - base != N + 1) begin
            failures++; $display("FAIL table_size: got %0d want %0d", res_cyc.size() - base, N + 1);
        end
        for (int n = 0; n <= N && base + n < res_cyc.size(); n++) begin
            if (res_val[base + n] !== is_prime(n)) bad++;
            if (res_val[base + n] === 1'b1) primes++;
        end
        checks++;
        if (bad != 0 || primes != model_count()) begin
            failures++; $display("FAIL table_contents: %0d wrong, %0d primes want 0 wrong %0d primes", bad, primes, model_count());
        end
    endtask

    task automatic test_restart();
        int c0 = clr_runs;
        int base;
        int exp_c;
        int   ec[$];
        logic ev[$];
        pulse_start();
        repeat (3) @(negedge clk);
        pulse_start();
        repeat ($urandom_range(20, 40)) @(negedge clk);
        pulse_start();
        wait_done("restart_first");
        checks++;
        if (clr_runs - c0 != 1) begin failures++; $display("FAIL ignored_start: %0d clear runs want 1", clr_runs - c0); end
        base = res_cyc.size();
        @(negedge clk); bus.q_valid = 1'b1; bus.q_num = AW'(29); exp_c = cyc + 3;
        @(negedge clk); bus.q_valid = 1'b0; bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        checks++;
        if (bus.done !== 1'b0 || bus.q_ready !== 1'b0 || bus.busy !== 1'b1) begin
            failures++; $display("FAIL restart_drop: done=%b q_ready=%b busy=%b want 0 0 1", bus.done, bus.q_ready, bus.busy);
        end
`ifdef SIEVE_CNT_EN
        checks++;
        if (bus.prime_count !== '0) begin failures++; $display("FAIL count_cleared: got %0d want 0", bus.prime_count); end
`endif
        wait_done("restart_second");
        checks++;
        if (res_cyc.size() - base != 1 || res_val[base] !== 1'b1 || res_cyc[base] != exp_c) begin
            failures++; $display("FAIL inflight_query: %0d results, first cyc %0d want 1 result prime=1 at cyc %0d",
                                 res_cyc.size() - base, (res_cyc.size() > base) ? res_cyc[base] : -1, exp_c);
        end
        checks++;
        if (clr_runs - c0 != 2) begin failures++; $display("FAIL restart_clear: %0d clear runs want 2", clr_runs - c0); end
        base = res_cyc.size();
        for (int k = 0; k < 16; k++) begin
            int n = int'($urandom_range(0, 35));
            @(negedge clk);
            bus.q_valid = 1'b1; bus.q_num = AW'(n);
            ec.push_back(cyc + 3); ev.push_back(is_prime(n));
        end
        @(negedge clk); bus.q_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (res_cyc.size() - base != ec.size()) begin
            failures++; $display("FAIL restart_query_count: got %0d want %0d", res_cyc.size() - base, ec.size());
        end
        for (int k = 0; k < ec.size() && base + k < res_cyc.size(); k++) begin
            checks++;
            if (res_val[base + k] !== ev[k] || res_cyc[base + k] != ec[k]) begin
                failures++;
                $display("FAIL restart_query_%0d: got prime=%b at cyc %0d want prime=%b at cyc %0d",
                         k, res_val[base + k], res_cyc[base + k], ev[k], ec[k]);
            end
        end
    endtask

`ifdef SIEVE_CNT_EN
    task automatic test_count();
        checks++;
        if (bus.prime_count !== AW'(model_count())) begin
            failures++; $display("FAIL prime_count: got %0d want %0d", bus.prime_count, model_count());
        end
    endtask
`endif

    initial begin
        bus.start = 1'b0; bus.q_valid = 1'b0; bus.q_num = '0;
        test_reset();
        test_sieve();
        test_queries();
`ifdef SIEVE_CNT_EN
        test_count();
`endif
        test_busy_query();
        test_reset_mid_mark();
        test_restart();
`ifdef SIEVE_CNT_EN
        test_count();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule

// File: doc/sieve_ctrl.md
Name: sieve_ctrl

Overview:
Sequencer for the 1-bit-wide dual-port prime RAM (write port A, read port B). On start, it runs a sieve of Eratosthenes over 0..N: it clears the RAM, then marks composites (bit=1 means composite). After that it serves primality queries through the RAM read port. It sits between the top-level control/display logic and the RAM IP instance.

Parameters:
N, 1023, largest number sieved; RAM addresses 0..N are used.
AW, 20, RAM address width; requires N < 2**AW.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
start  input  1  one-cycle pulse to begin a sieve; ignored while busy=1
busy  output  1  high from the cycle after start is accepted until sieve completion
done  output  1  high while the table is valid and the query port is live
ram_we  output  1  RAM port A write enable
ram_waddr  output  AW  RAM port A address
ram_wdata  output  1  RAM port A data (1=composite)
ram_raddr  output  AW  RAM port B address
ram_rdata  input  1  RAM port B data; synchronous read, valid one cycle after the address is sampled
q_valid  input  1  query request
q_num  input  AW  number to test
q_ready  output  1  equals done; query accepted on q_valid&&q_ready
r_valid  output  1  one-cycle result strobe
r_prime  output  1  1 = q_num is prime

Behaviour:
- Reset: all outputs are 0, FSM goes to IDLE, i=2, sq=4. Reset mid-sieve aborts the run. RAM contents are then undefined, so done stays 0 until a new start completes.
- All outputs are registered.
- FSM states: IDLE, CLEAR, RD_I, WAIT, CHK, MARK, NEXT, DONE (COUNT when SIEVE_CNT_EN is defined).
- IDLE: on start, go to CLEAR and set busy=1 and done=0.
- CLEAR: write 0 to addresses 0..N, one per cycle (ram_we=1), taking N+1 cycles. Then set i=2, sq=4 and go to RD_I. If N<4, go straight to DONE.
- RD_I: ram_raddr<=i. WAIT: idle one cycle. CHK: sample ram_rdata. If 0 (i is prime), set j=sq and go to MARK. If 1, go to NEXT.
- MARK: write 1 to address j and set j<=j+i. Leave for NEXT after the write where j+i>N. j must never wrap; compute j+i in AW+1 bits.
- NEXT: i<=i+1 and sq<=sq+2i+1 (no multiplier; sq is held in 2*AW bits). If the new sq>N, go to DONE (or COUNT); otherwise go to RD_I.
- DONE: busy=0, done=1, q_ready=1.
- Query pipeline: on acceptance at edge t, ram_raddr<=q_num at t. The RAM samples at t+1. At t+2 the block sets r_valid=1 for one cycle with r_prime = ~ram_rdata.
- Overrides: q_num 0 or 1 gives r_prime=0. q_num>N gives r_prime=0. Both keep the same 2-cycle latency.
- Queries may be back-to-back, one per cycle; results return in order.
- start while in DONE restarts the sieve. q_ready drops on the same edge. An in-flight query still completes its r_valid strobe.
- start while busy is ignored.
- q_valid while q_ready=0 is ignored. No result is produced.
- ram_we is 0 in every state except CLEAR and MARK.

Optional Feature:
Macro SIEVE_CNT_EN.
- Defined: adds output prime_count [AW-1:0] (reset 0) and state COUNT, entered after the sieve instead of DONE.
- COUNT streams reads of addresses 2..N, one per cycle, with the same 2-cycle read pipeline. It adds 1 for each 0 read. It goes to DONE after the last result is accumulated, so done rises N+2 cycles later than without the feature.
- prime_count is held until the next start, which clears it.
- Not defined: no port, no COUNT state, and the sieve ends directly in DONE.

Test Plan:
1. N=30. Reset, pulse start -> busy=1 next cycle; CLEAR shows ram_we=1 for exactly 31 cycles on addresses 0..30 with data 0; done=1 after the run.
2. N=30, after done -> queries 2,3,29,27,25,1,0 return r_prime=1,1,1,0,0,0,0. Each r_valid arrives exactly 2 cycles after acceptance, all issued back-to-back.
3. N=30 -> query 31 gives r_prime=0. Query during busy -> q_ready=0 and no r_valid.
4. N=30. Assert rst during MARK of i=3 -> all outputs 0 immediately. New start -> full correct table (29 prime, 9 not prime).
5. N=30. start pulse while busy -> ignored, with CLEAR run count still 1. start while done -> done drops, CLEAR reruns, results are still correct.
6. SIEVE_CNT_EN defined. N=30 -> prime_count=10. N=100 -> prime_count=25. N=1023 -> prime_count=172.
